// File: rtl/cp0_exception_unit_if.sv
// ----------------------------------------------------------------------------
// cp0_exception_unit_if
// Bus between the pipeline (master) and the CP0 register file / exception
// controller (slave).
//   pc_in     : PC of the instruction in the current cycle
//   din       : MTC0 write data (GPR rt)
//   regsel    : CP0 register number (rd field)
//   IsCOP0    : COP0-class instruction this cycle
//   IsMTC0    : with IsCOP0, MTC0 write
//   IsEret    : with IsCOP0, ERET
//   syscall   : SYSCALL this cycle
//   hw_int    : level-sensitive hardware interrupt lines
//   dout      : MFC0 read data (combinational on regsel)
//   CP0_PCout : current EPC, used as the ERET target
//   HasExp    : exception/interrupt taken this cycle
// ----------------------------------------------------------------------------
interface cp0_exception_unit_if;
    logic [31:0] pc_in;
    logic [31:0] din;
    logic [4:0]  regsel;
    logic        IsCOP0;
    logic        IsMTC0;
    logic        IsEret;
    logic        syscall;
    logic [5:0]  hw_int;
    logic [31:0] dout;
    logic [31:0] CP0_PCout;
    logic        HasExp;

    modport master (
        output pc_in, din, regsel, IsCOP0, IsMTC0, IsEret, syscall, hw_int,
        input  dout, CP0_PCout, HasExp
    );

    modport slave (
        input  pc_in, din, regsel, IsCOP0, IsMTC0, IsEret, syscall, hw_int,
        output dout, CP0_PCout, HasExp
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// ----------------------------------------------------------------------------
// cp0_exception_unit
// Coprocessor-0 register file (Status 12, Cause 13, EPC 14, PRId 15) and
// exception controller. Raises HasExp for an unmasked interrupt or a syscall,
// captures the faulting PC into EPC and supplies EPC for ERET.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : cp0_exception_unit_if.slave (request inputs, dout/CP0_PCout/HasExp)
// ----------------------------------------------------------------------------
module cp0_exception_unit #(
    parameter logic [31:0] PRID = 32'h0000_4D50
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_exception_unit_if.slave  bus
);

    // Only the implemented fields are stored; all other bits read as zero.
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:2] r_epc;

    logic        w_int_req;
    logic        w_sys_req;
    logic        w_has_exp;
    logic        w_mtc0;
    logic        w_eret;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_epc;
    logic        w_unused_pc;

    assign w_status = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause  = {16'd0, r_ip, 3'd0, r_exccode, 2'd0};
    assign w_epc    = {r_epc, 2'b00};

    // EXL masks both sources, so no nested exception while in a handler.
    assign w_int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign w_sys_req = bus.syscall & ~r_exl;
    assign w_has_exp = w_int_req | w_sys_req;

    // A taken exception discards any COP0 side effect in the same cycle.
    assign w_mtc0 = bus.IsCOP0 & bus.IsMTC0 & ~w_has_exp;
    assign w_eret = bus.IsCOP0 & bus.IsEret & ~w_has_exp;

    // PC is word aligned; the low bits never reach EPC.
    assign w_unused_pc = ^bus.pc_in[1:0];

    assign bus.HasExp    = w_has_exp;
    assign bus.CP0_PCout = w_epc;

    always_comb begin
        bus.dout = 32'd0;
        case (bus.regsel)
            5'd12:   bus.dout = w_status;
            5'd13:   bus.dout = w_cause;
            5'd14:   bus.dout = w_epc;
            5'd15:   bus.dout = PRID;
            default: bus.dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            // IP is a plain one-cycle sample of the interrupt lines.
            r_ip <= bus.hw_int;

            if (w_has_exp) begin
                r_epc     <= bus.pc_in[31:2];
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? 5'd0 : 5'd8;
            end else begin
                if (w_eret)
                    r_exl <= 1'b0;
                // Placed after ERET so an explicit Status write wins.
                if (w_mtc0) begin
                    case (bus.regsel)
                        5'd12: begin
                            r_im  <= bus.din[15:10];
                            r_exl <= bus.din[1];
                            r_ie  <= bus.din[0];
                        end
                        5'd14:   r_epc <= bus.din[31:2];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
